// File: rtl/reconfig_sram_pkg.sv
// Shared types and helpers for the IB LUT simple-dual-port SRAM.
// Holds the init FSM state type, the address legality check and latency cap.
package reconfig_sram_pkg;

  localparam int RD_LAT_MAX = 2;

  typedef enum logic {
    CLEAR,
    READY
  } sram_init_state_t;

  function automatic logic chk_addr(
    input logic [31:0] addr,
    input int unsigned page_num
  );
    return addr < page_num;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data pipeline: DEPTH stages of {valid,data}, sync active-low clear.
// Ports: clk, rst_n, vld_i/dat_i in, vld_o/dat_o out; DEPTH=0 is a wire.
module sram_rd_pipe #(
  parameter int PAGE_SIZE = 4,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_i,
  input  logic [PAGE_SIZE-1:0] dat_i,
  output logic                 vld_o,
  output logic [PAGE_SIZE-1:0] dat_o
);

  if (DEPTH == 0) begin : g_wire
    assign vld_o = vld_i;
    assign dat_o = dat_i;
  end else begin : g_reg
    logic [DEPTH-1:0]                vld_q, vld_d;
    logic [DEPTH-1:0][PAGE_SIZE-1:0] dat_q, dat_d;

    // Data only moves with a valid beat, so the output
    // holds its last value on idle cycles.
    always_comb begin
      vld_d    = '0;
      dat_d    = dat_q;
      vld_d[0] = vld_i;
      if (vld_i) dat_d[0] = dat_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign dat_o = dat_q[DEPTH-1];
  end

endmodule

// File: rtl/reconfig_sdp_sram_init.sv
// Simple-dual-port SRAM with auto-clear after reset and address checking.
// Ports: sys_clk, rstn; write wdata_i/waddr_i/wen_i; read raddr_i/ren_i
// -> rdata_o/rvalid_o; status init_done_o, addr_err_o. Enables active low.
module reconfig_sdp_sram_init
  import reconfig_sram_pkg::*;
#(
  parameter int ADDR_BITWIDTH    = 6,
  parameter int PAGE_SIZE        = 4,
  parameter int PAGE_NUM         = 64,
  parameter int RD_LATENCY       = 1,
  parameter int RDW_MODE         = 0,
  parameter int XILINX_FPGA_TECH = 1
) (
  input  logic                     sys_clk,
  input  logic                     rstn,
  input  logic [PAGE_SIZE-1:0]     wdata_i,
  input  logic [ADDR_BITWIDTH-1:0] waddr_i,
  input  logic                     wen_i,
  input  logic [ADDR_BITWIDTH-1:0] raddr_i,
  input  logic                     ren_i,
  output logic [PAGE_SIZE-1:0]     rdata_o,
  output logic                     rvalid_o,
  output logic                     init_done_o,
  output logic                     addr_err_o
);

  localparam int CNT_W = $clog2(PAGE_NUM + 1);

  if (PAGE_NUM > 2**ADDR_BITWIDTH ||
      RD_LATENCY > RD_LAT_MAX) begin : g_bad_cfg
    $error("reconfig_sdp_sram_init: bad PAGE_NUM/RD_LATENCY");
  end

  sram_init_state_t       state_q, state_d;
  logic [CNT_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic                   init_done_q, init_done_d;
  logic                   addr_err_q, addr_err_d;

  logic                     wr_ok, rd_ok, rd_go, rdw_hit;
  logic                     mem_we;
  logic [ADDR_BITWIDTH-1:0] mem_wa;
  logic [PAGE_SIZE-1:0]     mem_wd, mem_rd, rd_data;

  assign wr_ok = chk_addr(32'(waddr_i), PAGE_NUM);
  assign rd_ok = chk_addr(32'(raddr_i), PAGE_NUM);

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == CNT_W'(PAGE_NUM - 1)) begin
        state_d     = READY;
        init_done_d = 1'b1;
      end
    end
  end

  // The sweep owns the write port until every page is zero.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = waddr_i;
    mem_wd = wdata_i;
    if (state_q == CLEAR) begin
      mem_we = rstn;
      mem_wa = ADDR_BITWIDTH'(clr_cnt_q);
      mem_wd = '0;
    end else begin
      mem_we = rstn && !wen_i && wr_ok;
    end
  end

  if (XILINX_FPGA_TECH != 0) begin : g_xil
    (* ram_style = "distributed" *)
    logic [PAGE_SIZE-1:0] mem [PAGE_NUM];
    always_ff @(posedge sys_clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
    end
    assign mem_rd = mem[raddr_i];
  end else begin : g_gen
    logic [PAGE_SIZE-1:0] mem [PAGE_NUM];
    always_ff @(posedge sys_clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
    end
    assign mem_rd = mem[raddr_i];
  end

  // Write-first forwards wdata_i; read-first sees the
  // array before the edge commits the write.
  always_comb begin
    rdw_hit = (RDW_MODE != 0) && mem_we &&
              (state_q == READY) && (waddr_i == raddr_i);
    rd_go   = !ren_i && init_done_q;
    rd_data = mem_rd;
    if (!rd_ok)       rd_data = '0;
    else if (rdw_hit) rd_data = wdata_i;
    addr_err_d = init_done_q &&
                 ((!wen_i && !wr_ok) || (!ren_i && !rd_ok));
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      addr_err_q  <= addr_err_d;
    end
  end

  sram_rd_pipe #(
    .PAGE_SIZE (PAGE_SIZE),
    .DEPTH     (RD_LATENCY)
  ) u_rd_pipe (
    .clk   (sys_clk),
    .rst_n (rstn),
    .vld_i (rd_go),
    .dat_i (rd_data),
    .vld_o (rvalid_o),
    .dat_o (rdata_o)
  );

  assign init_done_o = init_done_q;
  assign addr_err_o  = addr_err_q;

endmodule
